// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
// Fetch FSM encoding, instruction/address widths and the default end-of-program marker.
package prefetch_pkg;
  localparam int INSTR_W    = 16;
  localparam int ROM_ADDR_W = 8;
  localparam int BYTE_W     = INSTR_W / 2;

  localparam logic [INSTR_W-1:0] END_WORD_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    FETCH_HI,
    FETCH_LO,
    HALT
  } fetch_state_t;
endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH x W FIFO with combinational head; push/pop take effect on the clock edge.
// Push into a full FIFO is accepted only together with a pop; pop of an empty FIFO is ignored.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until a push has written it.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end
endmodule

// File: rtl/instr_prefetch.sv
// Walks the program ROM, packs byte pairs (high first) into instructions and issues them to the decoder.
// First issue 3 edges after reset; a full FIFO stalls fetch in FETCH_LO, decoder ready gates issue.
module instr_prefetch
  import prefetch_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter logic [INSTR_W-1:0] END_WORD = END_WORD_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ROM_ADDR_W-1:0]   rom_address,
  input  logic [BYTE_W-1:0]       data_from_rom,
  input  logic                    ready_from_decoder,
  output logic                    start_for_decoder,
  output logic [INSTR_W-1:0]      data_for_decoder,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    done
);
  fetch_state_t          r_state;
  logic [BYTE_W-1:0]     r_hi;
  logic [ROM_ADDR_W-1:0] r_rom_address;
  logic                  r_start;
  logic [INSTR_W-1:0]    r_data;
  logic                  r_done;

  logic [INSTR_W-1:0]    w_word;
  logic [INSTR_W-1:0]    w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_end;
  logic                  w_push;
  logic                  w_pop;

  assign w_word = {r_hi, data_from_rom};
  assign w_end  = (r_state == FETCH_LO) && (w_word == END_WORD);
  // Gating on r_start guarantees an idle cycle between issues for the decoder to drop ready.
  assign w_pop  = !w_empty && ready_from_decoder && !r_start;
  assign w_push = (r_state == FETCH_LO) && !w_end && (!w_full || w_pop);

  instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_word),
    .rdata (w_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= FETCH_HI;
      r_hi          <= '0;
      r_rom_address <= '0;
    end else begin
      case (r_state)
        FETCH_HI: begin
          r_hi          <= data_from_rom;
          r_rom_address <= r_rom_address + 1'b1;
          r_state       <= FETCH_LO;
        end
        FETCH_LO: begin
          if (w_end) begin
            r_state <= HALT;
          end else if (w_push) begin
            // Top of ROM ends the program rather than wrapping to 0.
            if (r_rom_address == '1) begin
              r_state <= HALT;
            end else begin
              r_rom_address <= r_rom_address + 1'b1;
              r_state       <= FETCH_HI;
            end
          end
        end
        default: r_state <= HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_start <= w_pop;
      if (w_pop) r_data <= w_head;
      if (r_state == HALT && w_empty && !r_start && ready_from_decoder) r_done <= 1'b1;
    end
  end

  assign rom_address       = r_rom_address;
  assign start_for_decoder = r_start;
  assign data_for_decoder  = r_data;
  assign done              = r_done;
endmodule
